// File: rtl/wb_stage_pipe.sv
// RV32I write-back stage: source select, load alignment/extension, write gating,
// 2-entry skid buffer with valid/ready on both sides, and a retired-write counter.
module wb_stage_pipe #(
    parameter int XLEN  = 32,
    parameter int NSRC  = 4,
    parameter int SEL_W = $clog2(NSRC),
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 VALID_IN,
    output logic                 READY_OUT,
    input  logic [SEL_W-1:0]     CRT_WB_SEL,
    input  logic [NSRC*XLEN-1:0] DATA_IN,
    input  logic [2:0]           LOAD_FUNCT3,
    input  logic [1:0]           ADDR_LSB,
    input  logic [RA_W-1:0]      RD_IN,
    input  logic                 WE_IN,
    input  logic                 FLUSH,
    output logic                 VALID_OUT,
    input  logic                 READY_IN,
    output logic [XLEN-1:0]      DATA_OUT,
    output logic [RA_W-1:0]      RD_OUT,
    output logic                 WE_OUT,
    output logic                 MISALIGN_OUT,
    output logic [CNT_W-1:0]     RETIRE_CNT
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [RA_W-1:0] rd;
        logic            we;
        logic            mis;
    } entry_t;

    state_t           state_q, state_d;
    logic             ready_q;
    entry_t           head_q, tail_q, fmt;
    logic [CNT_W-1:0] cnt_q;

    logic [XLEN-1:0]  src_sel, load_data;
    logic             sel_ok, load_bad;
    logic [31:0]      word_v;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic             accept, xfer;

    // Load extraction always works on the low word of source 0.
    assign word_v = DATA_IN[31:0];
    assign byte_v = word_v[{ADDR_LSB, 3'b000} +: 8];
    assign half_v = word_v[{ADDR_LSB[1], 4'b0000} +: 16];

    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        src_sel = '0;
        sel_ok  = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (int'(CRT_WB_SEL) == k) begin
                src_sel = DATA_IN[k*XLEN +: XLEN];
                sel_ok  = 1'b1;
            end
        end
    end

    always_comb begin
        load_data = '0;
        load_bad  = 1'b0;
        unique case (LOAD_FUNCT3)
            3'b000: load_data = XLEN'($signed(byte_v));
            3'b100: load_data = XLEN'(byte_v);
            3'b001: if (ADDR_LSB[0]) load_bad = 1'b1;
                    else             load_data = XLEN'($signed(half_v));
            3'b101: if (ADDR_LSB[0]) load_bad = 1'b1;
                    else             load_data = XLEN'(half_v);
            3'b010: if (ADDR_LSB != 2'b00) load_bad = 1'b1;
                    else                   load_data = XLEN'($signed(word_v));
            default: load_bad = 1'b1;
        endcase
    end

    always_comb begin
        fmt.data = '0;
        fmt.rd   = RD_IN;
        fmt.we   = 1'b0;
        fmt.mis  = 1'b0;
        if (sel_ok) begin
            if (CRT_WB_SEL == '0) begin
                if (load_bad) begin
                    fmt.mis = 1'b1;
                end else begin
                    fmt.data = load_data;
                    fmt.we   = WE_IN;
                end
            end else begin
                fmt.data = src_sel;
                fmt.we   = WE_IN;
            end
        end
        // x0 is hardwired: data still flows for forwarding, the write does not.
        if (RD_IN == '0) fmt.we = 1'b0;
    end

    assign accept = VALID_IN & ready_q & ~FLUSH;
    assign xfer   = (state_q != EMPTY) & READY_IN;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (accept) state_d = ONE;
            ONE: begin
                if (accept && !xfer)      state_d = FULL;
                else if (!accept && xfer) state_d = EMPTY;
            end
            FULL:  if (xfer) state_d = ONE;
            default: state_d = EMPTY;
        endcase
        if (FLUSH) state_d = EMPTY;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: the buffer entries are reset because the head is visible on the
    // outputs and must read as zero while in reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= EMPTY;
            ready_q <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != FULL);
            if (xfer && head_q.we) cnt_q <= cnt_q + CNT_W'(1);
            unique case (state_q)
                EMPTY: if (accept) head_q <= fmt;
                ONE: begin
                    if (accept && xfer) head_q <= fmt;
                    else if (accept)    tail_q <= fmt;
                end
                FULL:  if (xfer) head_q <= tail_q;
                default: ;
            endcase
        end
    end

    assign READY_OUT    = ready_q;
    assign VALID_OUT    = (state_q != EMPTY);
    assign DATA_OUT     = head_q.data;
    assign RD_OUT       = head_q.rd;
    assign WE_OUT       = head_q.we & VALID_OUT;
    assign MISALIGN_OUT = head_q.mis;
    assign RETIRE_CNT   = cnt_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe: formatting, buffering, flush, counter wrap, reset.
module tb_wb_stage_pipe;

    localparam int XLEN  = 32;
    localparam int NSRC  = 4;
    localparam int SEL_W = 2;
    localparam int RA_W  = 5;
    localparam int CNT_W = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 valid_in, ready_out;
    logic [SEL_W-1:0]     wb_sel;
    logic [NSRC*XLEN-1:0] data_in;
    logic [2:0]           funct3;
    logic [1:0]           addr_lsb;
    logic [RA_W-1:0]      rd_in;
    logic                 we_in, flush;
    logic                 valid_out, ready_in;
    logic [XLEN-1:0]      data_out;
    logic [RA_W-1:0]      rd_out;
    logic                 we_out, mis_out;
    logic [CNT_W-1:0]     retire_cnt;

    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    always #5 clk = ~clk;

    wb_stage_pipe #(.XLEN(XLEN), .NSRC(NSRC), .SEL_W(SEL_W), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .CLK(clk), .RST(rst), .VALID_IN(valid_in), .READY_OUT(ready_out),
        .CRT_WB_SEL(wb_sel), .DATA_IN(data_in), .LOAD_FUNCT3(funct3), .ADDR_LSB(addr_lsb),
        .RD_IN(rd_in), .WE_IN(we_in), .FLUSH(flush), .VALID_OUT(valid_out),
        .READY_IN(ready_in), .DATA_OUT(data_out), .RD_OUT(rd_out), .WE_OUT(we_out),
        .MISALIGN_OUT(mis_out), .RETIRE_CNT(retire_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_word(input logic [1:0] sel, input logic [31:0] val, input logic [4:0] rd);
        wb_sel = sel;
        data_in[sel*XLEN +: XLEN] = val;
        funct3 = 3'b010;
        addr_lsb = 2'b00;
        rd_in = rd;
        we_in = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_in = 1'b0; ready_in = 1'b0; flush = 1'b0;
        wb_sel = '0; data_in = '0; funct3 = '0; addr_lsb = '0; rd_in = '0; we_in = 1'b0;
        step(); step();
        checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready_out); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        checks++; if (we_out !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", we_out); end
        checks++; if (data_out !== '0 || rd_out !== '0 || mis_out !== 1'b0) begin
            errors++; $display("FAIL reset_head: data %h rd %0d mis %b want 0", data_out, rd_out, mis_out);
        end
        checks++; if (retire_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", retire_cnt); end
        rst = 1'b0;
        exp_cnt = '0;
        step();
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", ready_out); end
    endtask

    // Single transfer with READY_IN=1: check head one cycle after accept, then the counter.
    task automatic send_one(input string name, input logic [1:0] sel, input logic [2:0] f3,
                            input logic [1:0] lsb, input logic [4:0] rd, input logic we,
                            input logic [31:0] exp_data, input logic exp_we, input logic exp_mis);
        wb_sel = sel; funct3 = f3; addr_lsb = lsb; rd_in = rd; we_in = we;
        valid_in = 1'b1; ready_in = 1'b1;
        step();
        valid_in = 1'b0;
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL %s valid: got %b want 1", name, valid_out); end
        checks++; if (data_out !== exp_data) begin errors++; $display("FAIL %s data: got %h want %h", name, data_out, exp_data); end
        checks++; if (we_out !== exp_we) begin errors++; $display("FAIL %s we: got %b want %b", name, we_out, exp_we); end
        checks++; if (mis_out !== exp_mis) begin errors++; $display("FAIL %s mis: got %b want %b", name, mis_out, exp_mis); end
        checks++; if (rd_out !== rd) begin errors++; $display("FAIL %s rd: got %0d want %0d", name, rd_out, rd); end
        if (exp_we) exp_cnt++;
        step();
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL %s cnt: got %0d want %0d", name, retire_cnt, exp_cnt); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL %s drain: got %b want 0", name, valid_out); end
    endtask

    task automatic test_select();
        data_in[1*XLEN +: XLEN] = 32'h0000_1234;
        send_one("sel1", 2'd1, 3'b000, 2'd3, 5'd5, 1'b1, 32'h0000_1234, 1'b1, 1'b0);
        data_in[3*XLEN +: XLEN] = 32'hCAFE_0003;
        send_one("sel3_nowe", 2'd3, 3'b000, 2'd0, 5'd9, 1'b0, 32'hCAFE_0003, 1'b0, 1'b0);
        data_in[2*XLEN +: XLEN] = 32'hDEAD_BEEF;
        send_one("rd0", 2'd2, 3'b010, 2'd0, 5'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    endtask

    task automatic test_loads();
        data_in[0 +: XLEN] = 32'h80FF_7F01;
        send_one("lb3",   2'd0, 3'b000, 2'd3, 5'd1, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b0);
        send_one("lbu3",  2'd0, 3'b100, 2'd3, 5'd2, 1'b1, 32'h0000_0080, 1'b1, 1'b0);
        send_one("lb1",   2'd0, 3'b000, 2'd1, 5'd3, 1'b1, 32'h0000_007F, 1'b1, 1'b0);
        send_one("lh2",   2'd0, 3'b001, 2'd2, 5'd4, 1'b1, 32'hFFFF_80FF, 1'b1, 1'b0);
        send_one("lhu0",  2'd0, 3'b101, 2'd0, 5'd6, 1'b1, 32'h0000_7F01, 1'b1, 1'b0);
        send_one("lhu2",  2'd0, 3'b101, 2'd2, 5'd7, 1'b1, 32'h0000_80FF, 1'b1, 1'b0);
        send_one("lw0",   2'd0, 3'b010, 2'd0, 5'd8, 1'b1, 32'h80FF_7F01, 1'b1, 1'b0);
        send_one("lh1",   2'd0, 3'b001, 2'd1, 5'd10, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
        send_one("lw2",   2'd0, 3'b010, 2'd2, 5'd11, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
        send_one("ill011", 2'd0, 3'b011, 2'd0, 5'd12, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        ready_in = 1'b0;
        drive_word(2'd1, 32'hAAAA_0001, 5'd13); valid_in = 1'b1;
        step();  // A accepted
        checks++; if (ready_out !== 1'b1 || data_out !== 32'hAAAA_0001) begin
            errors++; $display("FAIL b2b_a: ready %b data %h want 1 aaaa0001", ready_out, data_out);
        end
        drive_word(2'd1, 32'hBBBB_0002, 5'd14);
        step();  // B accepted, buffer full
        checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b want 0", ready_out); end
        drive_word(2'd1, 32'hCCCC_0003, 5'd15);
        step();  // C held upstream
        checks++; if (ready_out !== 1'b0 || valid_out !== 1'b1 || data_out !== 32'hAAAA_0001 || rd_out !== 5'd13) begin
            errors++; $display("FAIL b2b_hold: ready %b valid %b data %h rd %0d want 0 1 aaaa0001 13", ready_out, valid_out, data_out, rd_out);
        end
        ready_in = 1'b1;
        step();  // A out
        checks++; if (valid_out !== 1'b1 || data_out !== 32'hBBBB_0002 || ready_out !== 1'b1) begin
            errors++; $display("FAIL b2b_b: valid %b data %h ready %b want 1 bbbb0002 1", valid_out, data_out, ready_out);
        end
        step();  // B out, C accepted
        valid_in = 1'b0;
        checks++; if (valid_out !== 1'b1 || data_out !== 32'hCCCC_0003 || rd_out !== 5'd15) begin
            errors++; $display("FAIL b2b_c: valid %b data %h rd %0d want 1 cccc0003 15", valid_out, data_out, rd_out);
        end
        step();  // C out
        exp_cnt += 3;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", valid_out); end
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL b2b_cnt: got %0d want %0d", retire_cnt, exp_cnt); end
    endtask

    task automatic test_flush();
        ready_in = 1'b0;
        drive_word(2'd1, 32'h1111_0001, 5'd3); valid_in = 1'b1;
        step(); step();  // full
        flush = 1'b1;
        drive_word(2'd1, 32'h2222_0002, 5'd4);
        step();
        flush = 1'b0; valid_in = 1'b0;
        checks++; if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
            errors++; $display("FAIL flush_full: valid %b ready %b want 0 1", valid_out, ready_out);
        end
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL flush_cnt: got %0d want %0d", retire_cnt, exp_cnt); end
        step();
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL flush_ignored_in: got %b want 0", valid_out); end
        // A transfer coinciding with FLUSH still retires.
        drive_word(2'd2, 32'h3333_0003, 5'd5); valid_in = 1'b1;
        step();
        valid_in = 1'b0; ready_in = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0;
        exp_cnt++;
        checks++; if (retire_cnt !== exp_cnt || valid_out !== 1'b0) begin
            errors++; $display("FAIL flush_xfer: cnt %0d valid %b want %0d 0", retire_cnt, valid_out, exp_cnt);
        end
    endtask

    task automatic test_wrap();
        rst = 1'b1; valid_in = 1'b0;
        step();
        rst = 1'b0;
        step();
        ready_in = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive_word(2'd3, 32'h5000_0000 + i, 5'd20); valid_in = 1'b1;
            step();
            checks++; if (valid_out !== 1'b1 || data_out !== 32'h5000_0000 + i) begin
                errors++; $display("FAIL wrap_stream%0d: valid %b data %h want 1 %h", i, valid_out, data_out, 32'h5000_0000 + i);
            end
        end
        valid_in = 1'b0;
        step();
        checks++; if (retire_cnt !== 4'd1) begin errors++; $display("FAIL wrap_cnt: got %0d want 1", retire_cnt); end
    endtask

    task automatic test_reset_full();
        ready_in = 1'b0;
        drive_word(2'd1, 32'h7777_0007, 5'd7); valid_in = 1'b1;
        step(); step();
        rst = 1'b1; valid_in = 1'b0;
        step();
        checks++; if (valid_out !== 1'b0 || ready_out !== 1'b0 || we_out !== 1'b0 || data_out !== '0 ||
                      rd_out !== '0 || mis_out !== 1'b0 || retire_cnt !== '0) begin
            errors++; $display("FAIL rst_full: valid %b ready %b we %b data %h rd %0d mis %b cnt %0d want all 0",
                               valid_out, ready_out, we_out, data_out, rd_out, mis_out, retire_cnt);
        end
        rst = 1'b0;
        step();
        checks++; if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
            errors++; $display("FAIL rst_full_release: ready %b valid %b want 1 0", ready_out, valid_out);
        end
    endtask

    initial begin
        test_reset();
        test_select();
        test_loads();
        test_back_to_back();
        test_flush();
        test_wrap();
        test_reset_full();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
Parametrised write-back stage for the RV32I pipeline. It selects the result from NSRC sources, aligns and extends load data, and gates register-file writes. It buffers results in a 2-entry skid buffer with valid/ready handshakes on both sides and counts retired writes. It sits between MEM and the register file / forwarding network.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64.
NSRC, 4, number of result sources; source 0 is always memory load data.
SEL_W, $clog2(NSRC), width of the source select.
RA_W, 5, destination register address width.
CNT_W, 32, width of the retire counter.

Ports:
CLK  in  1  clock; all logic is on the rising edge.
RST  in  1  reset, synchronous, active-high.
VALID_IN  in  1  upstream result valid.
READY_OUT  out  1  stage can accept; registered.
CRT_WB_SEL  in  SEL_W  source select.
DATA_IN  in  NSRC*XLEN  flattened sources; source k occupies bits [k*XLEN +: XLEN].
LOAD_FUNCT3  in  3  load type; used only when CRT_WB_SEL==0.
ADDR_LSB  in  2  load byte address bits [1:0].
RD_IN  in  RA_W  destination register.
WE_IN  in  1  upstream write request.
FLUSH  in  1  synchronous drop of all buffered entries.
VALID_OUT  out  1  head entry valid.
READY_IN  in  1  downstream accepts the head entry.
DATA_OUT  out  XLEN  write-back data.
RD_OUT  out  RA_W  destination register.
WE_OUT  out  1  qualified write enable.
MISALIGN_OUT  out  1  head entry was a misaligned or illegal load.
RETIRE_CNT  out  CNT_W  count of transfers with WE_OUT=1.

Behaviour:
- Handshakes:
  - Input is accepted when VALID_IN & READY_OUT.
  - Output is transferred when VALID_OUT & READY_IN.
- Combinational formatting of the input entry, computed before buffering:
  - CRT_WB_SEL >= NSRC: data=0, WE forced 0.
  - CRT_WB_SEL != 0: data = the selected source, unmodified.
  - CRT_WB_SEL==0: byte/half/word extraction from source 0 using LOAD_FUNCT3 and ADDR_LSB.
    - 000 LB: sign-extend byte[ADDR_LSB].
    - 100 LBU: zero-extend byte[ADDR_LSB].
    - 001 LH / 101 LHU: sign- or zero-extend halfword[ADDR_LSB[1]]; ADDR_LSB[0]=1 is misaligned.
    - 010 LW: sign-extend word to XLEN; ADDR_LSB!=0 is misaligned.
    - 011, 110, 111: illegal.
  - Misaligned or illegal load: data=0, WE forced 0, misalign flag=1.
  - RD_IN==0: WE forced 0; data is passed through unchanged.
- Buffer: 2 entries, FIFO order. States are EMPTY, ONE, FULL.
  - EMPTY -> ONE on accept.
  - ONE -> FULL on accept without transfer.
  - ONE -> EMPTY on transfer without accept.
  - ONE stays ONE on simultaneous accept and transfer.
  - FULL -> ONE on transfer. No accept is possible in FULL.
- READY_OUT is registered and equals (next state != FULL), so upstream sees backpressure one cycle after the buffer fills. No entry is ever lost or duplicated.
- Latency: an accepted entry appears on the outputs the next cycle when the buffer was EMPTY. Throughput is 1 per cycle while READY_IN=1.
- VALID_OUT=(state != EMPTY). DATA_OUT, RD_OUT and MISALIGN_OUT always show the head entry. WE_OUT = head.WE & VALID_OUT.
- Holding rule: outputs stay stable while VALID_OUT & !READY_IN.
- FLUSH (priority over accept and transfer):
  - Next state is EMPTY and VALID_IN that cycle is ignored.
  - Any transfer in the FLUSH cycle still counts.
  - READY_OUT=1 the next cycle.
- RETIRE_CNT increments by 1 on every transfer with WE_OUT=1 and wraps from 2^CNT_W-1 to 0.
- Reset (RST high at a clock edge, including mid-operation):
  - state=EMPTY, READY_OUT=0, VALID_OUT=0, WE_OUT=0.
  - DATA_OUT=0, RD_OUT=0, MISALIGN_OUT=0, RETIRE_CNT=0.
  - READY_OUT rises to 1 on the first edge with RST low.

Test Plan:
- Reset, then SEL=1, DATA_IN[1]=0x0000_1234, RD_IN=5, WE_IN=1, READY_IN=1 -> next cycle VALID_OUT=1, DATA_OUT=0x0000_1234, RD_OUT=5, WE_OUT=1; RETIRE_CNT=1 after the transfer.
- SEL=0, source0=0x80FF_7F01:
  - LB with lsb=3 -> 0xFFFF_FF80.
  - LBU with lsb=3 -> 0x0000_0080.
  - LH with lsb=2 -> 0xFFFF_80FF.
  - LHU with lsb=0 -> 0x0000_7F01.
  - LH with lsb=1 -> DATA_OUT=0, WE_OUT=0, MISALIGN_OUT=1.
- RD_IN=0, WE_IN=1, data 0xDEAD_BEEF -> DATA_OUT=0xDEAD_BEEF, WE_OUT=0, RETIRE_CNT unchanged.
- READY_IN=0 with 3 back-to-back VALID_IN values A, B, C:
  - A and B are accepted; READY_OUT=0 from the cycle after B.
  - C is held upstream.
  - READY_IN=1 -> outputs A, B, C in order with no gaps once C is accepted.
- Buffer FULL, FLUSH=1 with VALID_IN=1 -> next cycle VALID_OUT=0, READY_OUT=1, RETIRE_CNT unchanged.
- CNT_W=4: 17 write transfers -> RETIRE_CNT=1 (wrap).
- RST asserted while FULL -> all outputs 0 at the next edge; READY_OUT=1 one cycle after RST drops.
